my_alu_pipe: RTL and testbench



---
 rtl/my_alu_pkg.sv | 26 ++
 rtl/my_alu_pre.sv | 26 ++
 rtl/my_alu_pipe.sv | 91 +++++++++
 tb/tb_my_alu_pipe.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/my_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : my_alu_pkg
// Description : Shared types and Hack ALU control encodings for my_alu_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
package my_alu_pkg;

  // Hack ALU control word, zx is the MSB
  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  localparam logic [5:0] ALU_ZERO   = 6'b101010;
  localparam logic [5:0] ALU_ADD    = 6'b000010;
  localparam logic [5:0] ALU_SUB_XY = 6'b010011;
  localparam logic [5:0] ALU_AND    = 6'b000000;
  localparam logic [5:0] ALU_OR     = 6'b010101;

endpackage
`default_nettype wire

// File: rtl/my_alu_pre.sv
`default_nettype none
// ============================================================================
// Module      : my_alu_pre
// Description : Combinational operand pre-processing: optional zero, then
//               optional bitwise inversion.
// Revision    : 1.0 - initial release
// ============================================================================
module my_alu_pre #(
  parameter int WIDTH = 16
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] in,
  input  logic             z,
  input  logic             n
);

  logic [WIDTH-1:0] zeroed;

  // Zero first, then negate, so z && n yields all ones
  always_comb begin
    zeroed = z ? '0 : in;
    out    = n ? ~zeroed : zeroed;
  end

endmodule
`default_nettype wire

// File: rtl/my_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : my_alu_pipe
// Description : Two-stage pipelined Hack ALU with valid/ready handshake on
//               both sides and registered zr/ng flags.
// Revision    : 1.0 - initial release
// ============================================================================
module my_alu_pipe
  import my_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             out_valid,
  input  logic             out_ready
);

  alu_ctrl_t        c;
  logic [WIDTH-1:0] px_d, py_d;
  logic [WIDTH-1:0] px, py;
  logic             s1_f, s1_no, s1_valid;
  logic             s2_adv, in_fire, s2_load;
  logic [WIDTH-1:0] r, core_out;

  assign c = alu_ctrl_t'(ctrl);

  my_alu_pre #(.WIDTH(WIDTH)) u_pre_x (.out(px_d), .in(x), .z(c.zx), .n(c.nx));
  my_alu_pre #(.WIDTH(WIDTH)) u_pre_y (.out(py_d), .in(y), .z(c.zy), .n(c.ny));

  // Handshake: stage 2 frees when empty or draining; stage 1 frees when
  // empty or moving forward, so bubbles collapse in the same cycle
  always_comb begin
    s2_adv   = !out_valid || out_ready;
    in_ready = rst_n && (!s1_valid || s2_adv);
    in_fire  = in_valid && in_ready;
    s2_load  = s1_valid && s2_adv;
  end

  // Stage-2 core: add/and, optional output negate
  always_comb begin
    r        = s1_f ? (px + py) : (px & py);
    core_out = s1_no ? ~r : r;
  end

  // Stage 1: capture pre-processed operands and function bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      px       <= '0;
      py       <= '0;
      s1_f     <= 1'b0;
      s1_no    <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      px       <= px_d;
      py       <= py_d;
      s1_f     <= c.f;
      s1_no    <= c.no;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: register result and flags from the same combinational value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      zr        <= 1'b0;
      ng        <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      out       <= core_out;
      zr        <= ~|core_out;
      ng        <= core_out[WIDTH-1];
    end else if (s2_adv) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_my_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_my_alu_pipe
// Description : Scoreboard bench for my_alu_pipe: directed vectors push
//               expected results, an independent monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_my_alu_pipe;
  import my_alu_pkg::*;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] out;
    logic         zr;
    logic         ng;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] x, y;
  logic [5:0]   ctrl;
  logic         in_valid, in_ready;
  logic [W-1:0] out;
  logic         zr, ng, out_valid, out_ready;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  res_t exp_q[$];
  int   pop_cyc[$];

  my_alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .ctrl(ctrl),
    .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .zr(zr), .ng(ng),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model of the ALU equations
  function automatic logic [W-1:0] pre(input logic [W-1:0] v, input logic z, input logic n);
    logic [W-1:0] t;
    t = z ? '0 : v;
    return n ? ~t : t;
  endfunction

  function automatic logic [W-1:0] alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] c);
    logic [W-1:0] pa, pb, rr;
    pa = pre(a, c[5], c[4]);
    pb = pre(b, c[3], c[2]);
    rr = c[1] ? pa + pb : pa & pb;
    return c[0] ? ~rr : rr;
  endfunction

  function automatic res_t mk(input logic [W-1:0] v);
    res_t t;
    t.out = v;
    t.zr  = (v == '0);
    t.ng  = v[W-1];
    return t;
  endfunction

  // Present a vector; the transfer is seen at the negedge before the edge
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [5:0] c, input logic [W-1:0] e);
    int n;
    @(posedge clk); #1;
    x = a; y = b; ctrl = c; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(mk(e));
        break;
      end
      n++;
      if (n > 50) begin
        checks++; failures++;
        $display("FAIL send_timeout: in_ready stuck low, required 1");
        in_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d results pending, required 0", exp_q.size());
    end
  endtask

  // Monitor: on every output transfer pop the oldest expectation and compare
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_result: got out=%h, required no output", out);
        end else begin
          e = exp_q.pop_front();
          pop_cyc.push_back(cyc);
          check("result_out", out, e.out);
          check("result_zr", {15'd0, zr}, {15'd0, e.zr});
          check("result_ng", {15'd0, ng}, {15'd0, e.ng});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] sa [8];
    logic [W-1:0] sb [8];
    logic [5:0]   sc [8];
    int           pops0;
    rst_n = 1'b0; x = '0; y = '0; ctrl = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_out_valid", {15'd0, out_valid}, 16'd0);
    check("reset_out", out, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", {15'd0, in_ready}, 16'd1);
    check("idle_zr_ng", {14'd0, zr, ng}, 16'd0);

    // Add with latency observation
    send(16'd5, 16'd3, ALU_ADD, 16'd8);
    idle();
    @(negedge clk);
    check("latency_edge_n", {15'd0, out_valid}, 16'd0);
    @(negedge clk);
    check("latency_edge_n1", {15'd0, out_valid}, 16'd1);
    drain();

    // Subtract, bitwise and zero
    send(16'd3, 16'd5, ALU_SUB_XY, 16'hFFFE);
    send(16'd7, 16'd7, ALU_SUB_XY, 16'h0000);
    send(16'h000C, 16'hE000, ALU_OR, 16'hE00C);
    send(16'h000C, 16'hE000, ALU_AND, 16'h0000);
    send(16'h1234, 16'hABCD, ALU_ZERO, 16'h0000);
    idle();
    drain();

    // Backpressure: two accepted, third blocked, output held
    @(posedge clk); #1; out_ready = 1'b0;
    send(16'd1, 16'd2, ALU_ADD, 16'h0003);
    send(16'd10, 16'd20, ALU_ADD, 16'h001E);
    @(posedge clk); #1;
    x = 16'h00F0; y = 16'h000F; ctrl = ALU_OR; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready_low", {15'd0, in_ready}, 16'd0);
      check("bp_out_stable", out, 16'h0003);
      check("bp_out_valid", {15'd0, out_valid}, 16'd1);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_release", {15'd0, in_ready}, 16'd1);
    if (in_ready) exp_q.push_back(mk(16'h00FF));
    idle();
    drain();
    repeat (3) @(negedge clk);

    // Streaming: 8 back-to-back transfers, model-derived expectations
    sa = '{16'h0001, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h00FF, 16'h1234, 16'h0000, 16'hAAAA};
    sb = '{16'h0001, 16'h0001, 16'h0001, 16'h8000, 16'h0F0F, 16'h4321, 16'hFFFF, 16'h5555};
    sc = '{ALU_ADD, ALU_ADD, ALU_ADD, ALU_SUB_XY, ALU_AND, ALU_OR, 6'b001100, 6'b110111};
    pops0 = pop_cyc.size();
    for (int i = 0; i < 8; i++) send(sa[i], sb[i], sc[i], alu(sa[i], sb[i], sc[i]));
    idle();
    drain();
    check("stream_count", 16'(pop_cyc.size() - pops0), 16'd8);
    if (pop_cyc.size() - pops0 == 8)
      check("stream_span", 16'(pop_cyc[pop_cyc.size()-1] - pop_cyc[pops0]), 16'd7);

    // Reset mid-operation with a full pipe
    @(posedge clk); #1; out_ready = 1'b0;
    send(16'd100, 16'd1, ALU_ADD, 16'd101);
    send(16'd200, 16'd1, ALU_ADD, 16'd201);
    idle();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_async_out", out, 16'd0);
    exp_q.delete();
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_out_valid", {15'd0, out_valid}, 16'd0);

    // Pipe accepts again after reset
    send(16'd9, 16'd6, ALU_SUB_XY, 16'd3);
    idle();
    drain();
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
